rfrac_q32_out_buf: RTL and testbench
====================================

# rfrac_q32_out_buf

Output stage placed directly downstream of the 18-bit RNS-to-fractional converter (`RFracConv18_16_dval`). Each cycle it can accept one converted word: sign, four 16-bit magnitude digits, and the overflow indicators. It converts the word to 64-bit two's-complement Q32.32, saturating where needed, and queues it in a small FIFO. The FIFO drains over a valid/ready stream, so a back-pressuring consumer (host bridge or accumulator) can be attached to a converter that has no ready input.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `AF_MARGIN`, 2: `almost_full` asserts when occupancy ≥ `DEPTH`−`AF_MARGIN`.
- `clk` in 1: single clock, rising edge.
- `aclr_n` in 1: reset, asynchronous assert and active-low; deassert synchronous to `clk` (decided).
- `datavalid_in` in 1: input word valid; no ready, and the word is sampled every cycle it is high.
- `sign_in` in 1: 1 means negative.
- `b3_in`,`b2_in`,`b1_in`,`b0_in` in 16 each: magnitude digits; {b3,b2} is the integer part, {b1,b0} the fraction.
- `ov1_in` in 1, `ov2_in` in 18: converter overflow indicators.
- `m_valid` out 1, `m_ready` in 1, `m_data` out 64, `m_sat` out 1: output stream; `m_sat` marks a saturated word.
- `almost_full` out 1, `fifo_count` out $clog2(DEPTH)+1.
- `sat_cnt` out 16, `drop_cnt` out 16: event counters; each saturates at 0xFFFF.

## Operation
- Magnitude M = {b3,b2,b1,b0}, 64-bit unsigned.
- Overflow condition OV = `ov1_in` | (|`ov2_in`) | (!sign & M[63]) | (sign & M > 2^63).
- Result when OV = 0: sign ? (~M + 1) mod 2^64 : M. Negative zero maps to 0. M = 2^63 with sign = 1 gives 0x8000_0000_0000_0000 and is not saturated.
- Result when OV = 1: sign ? 0x8000_0000_0000_0000 : 0x7FFF_FFFF_FFFF_FFFF, with `m_sat` = 1.
- Stage S1 registers the result, the sat flag and a valid bit. S1 writes into the FIFO one cycle after sampling.
- FIFO is first-word-fall-through: `m_data`/`m_sat` show the head whenever `m_valid` = 1. A pop is `m_valid & m_ready`.
- Push while full and no pop in the same cycle: the word is dropped, FIFO is unchanged, `drop_cnt` += 1.
- Push while full together with a pop: both happen, and occupancy stays at `DEPTH`.
- Push while empty together with `m_ready` = 1: no bypass. The word appears next cycle.
- `sat_cnt` += 1 for each saturated word at the S1 write, whether the word is dropped or not.
- Counters stop incrementing at 0xFFFF.
- Stream rule: once `m_valid` = 1 it stays high, with `m_data` stable, until a pop.

## Timing
- Latency: `datavalid_in` sampled at edge k → `m_valid` = 1 after edge k+1 (if the FIFO was empty).
- Throughput: 1 word/cycle while `m_ready` = 1.
- `fifo_count` and `almost_full` are registered and reflect the state after each edge.
- Reset values: `m_valid` = 0, `m_data` = 0, `m_sat` = 0, `almost_full` = 0, `fifo_count` = 0, `sat_cnt` = 0, `drop_cnt` = 0, S1 valid = 0.
- Reset asserted mid-stream clears all of the above immediately (asynchronously). In-flight and queued words are lost.
- The first word accepted after release is the one sampled on the first rising edge with `aclr_n` = 1.

## Structure
- Package `rfrac_pkg` holds:
  - `Q32_MAX`, `Q32_MIN` localparams.
  - `typedef struct packed {logic [63:0] data; logic sat;} rfrac_q32_t`.
  - Function `rfrac_to_q32(sign, mag, ov)` returning `rfrac_q32_t`.
- Sub-module `rfrac_sync_fifo`, parameterised on `DEPTH` and the element type. It owns the read/write pointers with an extra wrap bit, and produces full/empty/count/almost_full.
- Top level holds S1, the drop/saturation counters and the stream port.

## Test plan
- Single word: sign = 0, b1 = 0x8000, others 0 (0.5), with `m_ready` = 1 → `m_data` = 0x0000_0000_8000_0000 two edges later, `m_sat` = 0.
- Negation: sign = 1, b2 = 0x0001 (−1.0) → `m_data` = 0xFFFF_FFFF_0000_0000. Then sign = 0, b2 = 0x0064 (100.0) → 0x0000_0064_0000_0000 on the following cycle.
- Saturation:
  - `ov2_in` = 0x00001, sign = 1 → 0x8000_0000_0000_0000, `m_sat` = 1, `sat_cnt` = 1.
  - sign = 1, b3 = 0x8000 → 0x8000_0000_0000_0000 with `m_sat` = 0.
  - sign = 0, b3 = 0x8000 → 0x7FFF_FFFF_FFFF_FFFF with `m_sat` = 1.
- Backpressure: `m_ready` = 0, send 11 consecutive words →
  - `almost_full` goes high after 6 words are stored.
  - `fifo_count` = 8 and `drop_cnt` = 3.
  - Raising `m_ready` yields the first 8 words in order.
- Full with simultaneous push and pop: FIFO full, `m_ready` = 1 and `datavalid_in` = 1 for 4 cycles → no drops, count stays at 8, order preserved.
- Reset mid-stream: pulse `aclr_n` low for half a cycle with 5 words queued → `m_valid`, `fifo_count` and counters go to 0 immediately. A new word after release arrives with 2-cycle latency.

Source files
------------

// File: rtl/rfrac_pkg.sv
// Shared types and the converter-word to Q32.32 mapping used by the output buffer.
// Saturating Q32.32 conversion and counter helpers.
package rfrac_pkg;

    localparam logic [63:0] Q32_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] Q32_MIN = 64'h8000_0000_0000_0000;

    typedef struct packed {
        logic [63:0] data;
        logic        sat;
    } rfrac_q32_t;

    // ov carries the converter's own overflow flags.
    // Magnitude overflow is detected here: a negative word may reach exactly 2^63.
    function automatic rfrac_q32_t rfrac_to_q32(input logic        sign,
                                                input logic [63:0] mag,
                                                input logic        ov);
        rfrac_q32_t r;
        logic       mag_ov;
        mag_ov = sign ? (mag > Q32_MIN) : mag[63];
        r.sat  = ov | mag_ov;
        if (r.sat) begin
            r.data = sign ? Q32_MIN : Q32_MAX;
        end else begin
            r.data = sign ? (~mag + 64'd1) : mag;
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/rfrac_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers and a
// registered occupancy count and almost-full flag.
module rfrac_sync_fifo #(
    parameter int  DEPTH     = 8,
    parameter int  AF_MARGIN = 2,
    parameter type T         = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   push,
    input  logic                   pop,
    input  T                       wr_data,
    output T                       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int AF_LEVEL = DEPTH - AF_MARGIN;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rfrac_sync_fifo: DEPTH must be a power of two and at least 2");
    end

    T              mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          wr_en;
    logic          rd_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en   = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en   = push & (~full | rd_en);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: every path assigns count_nxt first so no latch is inferred.
    always_comb begin
        count_nxt = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count       <= count_nxt;
            almost_full <= (count_nxt >= CW'(AF_LEVEL));
        end
    end

    // NOTE: storage is deliberately not reset; empty gates everything read from it.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/rfrac_q32_out_buf.sv
// Output stage behind the RNS-to-fractional converter: saturating Q32.32
// conversion, one register stage, and a valid/ready FIFO with event counters.
module rfrac_q32_out_buf
    import rfrac_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   datavalid_in,
    input  logic                   sign_in,
    input  logic [15:0]            b3_in,
    input  logic [15:0]            b2_in,
    input  logic [15:0]            b1_in,
    input  logic [15:0]            b0_in,
    input  logic                   ov1_in,
    input  logic [17:0]            ov2_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [63:0]            m_data,
    output logic                   m_sat,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            sat_cnt,
    output logic [15:0]            drop_cnt
);

    rfrac_q32_t conv;
    rfrac_q32_t s1_q;
    rfrac_q32_t head;
    logic       s1_valid;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       drop;

    assign conv = rfrac_to_q32(sign_in, {b3_in, b2_in, b1_in, b0_in},
                               ov1_in | (|ov2_in));

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            s1_valid <= datavalid_in;
            if (datavalid_in) s1_q <= conv;
        end
    end

    rfrac_sync_fifo #(
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN),
        .T         (rfrac_q32_t)
    ) u_fifo (
        .clk         (clk),
        .aclr_n      (aclr_n),
        .push        (s1_valid),
        .pop         (m_ready),
        .wr_data     (s1_q),
        .rd_data     (head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count),
        .almost_full (almost_full)
    );

    assign m_valid = ~fifo_empty;
    assign m_data  = m_valid ? head.data : '0;
    assign m_sat   = m_valid & head.sat;
    assign pop     = m_valid & m_ready;
    assign drop    = s1_valid & fifo_full & ~pop;

    // Saturation is counted at the S1 write even if the word is then dropped.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            sat_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            sat_cnt  <= sat_inc16(sat_cnt, s1_valid & s1_q.sat);
            drop_cnt <= sat_inc16(drop_cnt, drop);
        end
    end

endmodule

// File: tb/tb_rfrac_q32_out_buf.sv
// Self-checking bench for rfrac_q32_out_buf: directed vectors, back-pressure,
// reset and randomized traffic against a queue-based reference model.
module tb_rfrac_q32_out_buf;

    localparam int DEPTH     = 8;
    localparam int AF_MARGIN = 2;
    localparam logic [63:0] MAXC = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINC = 64'h8000_0000_0000_0000;
    localparam logic signed [65:0] HI = 66'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] LO = -(66'sh8000_0000_0000_0000);

    logic        clk;
    logic        aclr_n;
    logic        datavalid_in;
    logic        sign_in;
    logic [15:0] b3_in, b2_in, b1_in, b0_in;
    logic        ov1_in;
    logic [17:0] ov2_in;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_sat;
    logic        almost_full;
    logic [3:0]  fifo_count;
    logic [15:0] sat_cnt;
    logic [15:0] drop_cnt;

    rfrac_q32_out_buf #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
        .clk          (clk),
        .aclr_n       (aclr_n),
        .datavalid_in (datavalid_in),
        .sign_in      (sign_in),
        .b3_in        (b3_in),
        .b2_in        (b2_in),
        .b1_in        (b1_in),
        .b0_in        (b0_in),
        .ov1_in       (ov1_in),
        .ov2_in       (ov2_in),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_sat        (m_sat),
        .almost_full  (almost_full),
        .fifo_count   (fifo_count),
        .sat_cnt      (sat_cnt),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        bit          sat;
    } exp_t;

    typedef struct {
        bit          sign;
        logic [63:0] mag;
        bit          ov1;
        logic [17:0] ov2;
        logic [63:0] exp_data;
        bit          exp_sat;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t mq[$];
    bit   ms1_v;
    exp_t ms1;
    int   msat;
    int   mdrop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: take the signed value the word denotes and clamp it to Q32.32.
    function automatic exp_t ref_conv(bit sign, logic [63:0] mag, bit ov1, logic [17:0] ov2);
        exp_t r;
        logic signed [65:0] v;
        v = sign ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
        if (ov1 || ov2 != 18'd0) begin
            r.data = sign ? MINC : MAXC;
            r.sat  = 1'b1;
        end else if (v > HI) begin
            r.data = MAXC;
            r.sat  = 1'b1;
        end else if (v < LO) begin
            r.data = MINC;
            r.sat  = 1'b1;
        end else begin
            r.data = v[63:0];
            r.sat  = 1'b0;
        end
        return r;
    endfunction

    task automatic drive(input bit v, input bit s, input logic [63:0] mag,
                         input bit o1, input logic [17:0] o2);
        datavalid_in = v;
        sign_in      = s;
        {b3_in, b2_in, b1_in, b0_in} = mag;
        ov1_in       = o1;
        ov2_in       = o2;
    endtask

    task automatic compare_all();
        check("m_valid", 64'(m_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("m_data", m_data, mq[0].data);
            check("m_sat", 64'(m_sat), 64'(mq[0].sat));
        end
        check("fifo_count", 64'(fifo_count), 64'(mq.size()));
        check("almost_full", 64'(almost_full), 64'(mq.size() >= DEPTH - AF_MARGIN));
        check("sat_cnt", 64'(sat_cnt), 64'(msat));
        check("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    endtask

    // Advance the model over one rising edge, then compare after the edge.
    task automatic step();
        bit   pop;
        bit   was_full;
        exp_t e;
        was_full = (mq.size() == DEPTH);
        pop      = (mq.size() != 0) && m_ready;
        if (pop) e = mq.pop_front();
        if (ms1_v) begin
            if (ms1.sat && msat < 65535) msat++;
            if (was_full && !pop) begin
                if (mdrop < 65535) mdrop++;
            end else begin
                mq.push_back(ms1);
            end
        end
        ms1_v = datavalid_in;
        ms1   = ref_conv(sign_in, {b3_in, b2_in, b1_in, b0_in}, ov1_in, ov2_in);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_model();
        mq.delete();
        ms1_v = 1'b0;
        mdrop = 0;
        msat  = 0;
    endtask

    // Half-cycle reset pulse starting just after a rising edge.
    task automatic pulse_reset();
        aclr_n = 1'b0;
        #1;
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_m_sat", 64'(m_sat), 64'd0);
        check("rst_almost_full", 64'(almost_full), 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        #4;
        aclr_n = 1'b1;
        clear_model();
    endtask

    function automatic logic [63:0] rand_mag();
        case ($urandom_range(0, 5))
            0:       return {$urandom(), $urandom()};
            1:       return MINC;
            2:       return MINC + 64'd1;
            3:       return 64'd0;
            4:       return MAXC;
            default: return {32'd0, $urandom()};
        endcase
    endfunction

    vec_t        vecs[10];
    logic [63:0] sent[13];
    logic [63:0] mag;

    initial begin
        vecs[0] = '{0, 64'h0000_0000_8000_0000, 0, 18'd0, 64'h0000_0000_8000_0000, 0};
        vecs[1] = '{1, 64'h0000_0001_0000_0000, 0, 18'd0, 64'hFFFF_FFFF_0000_0000, 0};
        vecs[2] = '{0, 64'h0000_0064_0000_0000, 0, 18'd0, 64'h0000_0064_0000_0000, 0};
        vecs[3] = '{1, 64'd0,                   0, 18'd1, 64'h8000_0000_0000_0000, 1};
        vecs[4] = '{1, 64'h8000_0000_0000_0000, 0, 18'd0, 64'h8000_0000_0000_0000, 0};
        vecs[5] = '{0, 64'h8000_0000_0000_0000, 0, 18'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1};
        vecs[6] = '{1, 64'd0,                   0, 18'd0, 64'd0,                   0};
        vecs[7] = '{1, 64'h8000_0000_0000_0001, 0, 18'd0, 64'h8000_0000_0000_0000, 1};
        vecs[8] = '{0, 64'h0000_0000_0000_0005, 1, 18'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1};
        vecs[9] = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 18'd0, 64'h7FFF_FFFF_FFFF_FFFF, 0};

        aclr_n  = 1'b0;
        m_ready = 1'b0;
        drive(0, 0, 64'd0, 0, 18'd0);
        clear_model();
        #3;
        check("init_m_valid", 64'(m_valid), 64'd0);
        check("init_m_data", m_data, 64'd0);
        check("init_fifo_count", 64'(fifo_count), 64'd0);
        check("init_sat_cnt", 64'(sat_cnt), 64'd0);
        @(posedge clk);
        #1;
        aclr_n = 1'b1;

        // Directed conversions, one word at a time with the consumer ready.
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1, vecs[i].sign, vecs[i].mag, vecs[i].ov1, vecs[i].ov2);
            step();
            drive(0, 0, 64'd0, 0, 18'd0);
            step();
            check("vec_valid", 64'(m_valid), 64'd1);
            check("vec_data", m_data, vecs[i].exp_data);
            check("vec_sat", 64'(m_sat), 64'(vecs[i].exp_sat));
            if (i == 3) check("sat_cnt_first", 64'(sat_cnt), 64'd1);
        end
        step();
        check("vec_sat_total", 64'(sat_cnt), 64'd4);

        // Back-to-back -1.0 then 100.0.
        drive(1, 1, 64'h0000_0001_0000_0000, 0, 18'd0);
        step();
        drive(1, 0, 64'h0000_0064_0000_0000, 0, 18'd0);
        step();
        check("neg_first", m_data, 64'hFFFF_FFFF_0000_0000);
        drive(0, 0, 64'd0, 0, 18'd0);
        step();
        check("neg_second", m_data, 64'h0000_0064_0000_0000);
        step();

        // Back-pressure: 11 words into an 8-deep FIFO.
        pulse_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            sent[i] = {1'b0, 31'($urandom()), $urandom()};
            drive(1, 0, sent[i], 0, 18'd0);
            step();
            if (i == 5) check("af_at_5", 64'(almost_full), 64'd0);
            if (i == 6) check("af_at_6", 64'(almost_full), 64'd1);
        end
        drive(0, 0, 64'd0, 0, 18'd0);
        step();
        check("bp_count", 64'(fifo_count), 64'd8);
        check("bp_drops", 64'(drop_cnt), 64'd3);
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("bp_order", m_data, sent[k]);
            step();
        end
        check("bp_empty", 64'(m_valid), 64'd0);

        // Full FIFO with a push and a pop on the same edge.
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            sent[i] = {1'b0, 31'($urandom()), $urandom()};
            drive(1, 0, sent[i], 0, 18'd0);
            step();
        end
        check("pp_full", 64'(fifo_count), 64'd8);
        m_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            sent[9 + j] = {1'b0, 31'($urandom()), $urandom()};
            drive(1, 0, sent[9 + j], 0, 18'd0);
            step();
            check("pp_count", 64'(fifo_count), 64'd8);
            check("pp_drops", 64'(drop_cnt), 64'd3);
        end
        drive(0, 0, 64'd0, 0, 18'd0);
        for (int k = 4; k < 13; k++) begin
            check("pp_order", m_data, sent[k]);
            step();
        end
        check("pp_empty", 64'(m_valid), 64'd0);

        // Reset with five words queued, then a fresh word after release.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, i[0], rand_mag(), 0, (i == 2) ? 18'h20000 : 18'd0);
            step();
        end
        drive(0, 0, 64'd0, 0, 18'd0);
        step();
        check("rs_queued", 64'(fifo_count), 64'd5);
        pulse_reset();
        m_ready = 1'b1;
        drive(1, 0, 64'h0000_0003_0000_0000, 0, 18'd0);
        step();
        check("rs_lat1", 64'(m_valid), 64'd0);
        drive(0, 0, 64'd0, 0, 18'd0);
        step();
        check("rs_lat2", 64'(m_valid), 64'd1);
        check("rs_data", m_data, 64'h0000_0003_0000_0000);

        // Randomized traffic with varying consumer readiness.
        for (int n = 0; n < 800; n++) begin
            mag = rand_mag();
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, mag,
                  $urandom_range(0, 15) == 0,
                  ($urandom_range(0, 15) == 0) ? 18'(1 << $urandom_range(0, 17)) : 18'd0);
            m_ready = (n % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step();
        end
        drive(0, 0, 64'd0, 0, 18'd0);
        m_ready = 1'b1;
        for (int n = 0; n < DEPTH + 3; n++) step();
        check("final_empty", 64'(m_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
